// File: rtl/seg7_pkg.sv
// Shared 7-segment glyph definitions (active-low, bits 6:0 = g..a) and decode helpers.
// The display driver reuses these glyph constants, so both sides of the bus agree on encoding.
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [3:0] BLANK_CODE = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_HOLD    = 2'd3
   } scan_state_e;

   // Returns {legal, nibble}; illegal glyphs report nibble = BLANK_CODE.
   function automatic logic [4:0] seg7_decode(input logic [6:0] s);
      logic [4:0] r;
      case (s)
         SEG_0:     r = {1'b1, 4'h0};
         SEG_1:     r = {1'b1, 4'h1};
         SEG_2:     r = {1'b1, 4'h2};
         SEG_3:     r = {1'b1, 4'h3};
         SEG_4:     r = {1'b1, 4'h4};
         SEG_5:     r = {1'b1, 4'h5};
         SEG_6:     r = {1'b1, 4'h6};
         SEG_7:     r = {1'b1, 4'h7};
         SEG_8:     r = {1'b1, 4'h8};
         SEG_9:     r = {1'b1, 4'h9};
         SEG_BLANK: r = {1'b1, BLANK_CODE};
         default:   r = {1'b0, BLANK_CODE};
      endcase
      return r;
   endfunction

   function automatic logic an_onehot(input logic [3:0] an);
      logic r;
      case (an)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: r = 1'b1;
         default:                            r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic [1:0] an_to_pos(input logic [3:0] an);
      logic [1:0] r;
      case (an)
         4'b1110: r = 2'd0;
         4'b1101: r = 2'd1;
         4'b1011: r = 2'd2;
         4'b0111: r = 2'd3;
         default: r = 2'd0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/seg_stale_timer.sv
// Per-position refresh watchdog: saturating cycle counter that drops valid when a
// position has not been recaptured within STALE_CYCLES.
module seg_stale_timer
   import seg7_pkg::*;
#(
   parameter int STALE_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   input  logic set,
   output logic valid
);

   localparam int CW = $clog2(STALE_CYCLES + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STALE_CYCLES);

   logic [CW-1:0] cnt_r;
   logic          valid_r;

   // Restart (capture) takes priority over expiry in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r   <= '0;
         valid_r <= 1'b0;
      end else if (restart) begin
         cnt_r <= '0;
         if (set) begin
            valid_r <= 1'b1;
         end
      end else if (cnt_r != LIMIT) begin
         cnt_r <= cnt_r + CW'(1);
         if (cnt_r == LIMIT - CW'(1)) begin
            valid_r <= 1'b0;
         end
      end
   end

   assign valid = valid_r;

endmodule

// File: rtl/seg_scan_decoder.sv
// Receive-side decoder for the multiplexed active-low seg/an display bus.
// Optional build macro SEG_SCAN_DECODER_ERRCNT_EN adds a saturating illegal-glyph counter err_cnt.
module seg_scan_decoder
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter int STALE_CYCLES  = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  seg,
   input  logic [3:0]  an,
   output logic [15:0] digits,
   output logic [3:0]  dp,
   output logic [3:0]  valid,
   output logic        update,
   output logic        err
`ifdef SEG_SCAN_DECODER_ERRCNT_EN
   ,output logic [7:0] err_cnt
`endif
);

   localparam int SW = $clog2(STABLE_CYCLES + 1);
   localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);

   logic [7:0]    seg_q_r;
   logic [3:0]    an_q_r;
   scan_state_e   state_r, state_n_s;
   logic [SW-1:0] stab_cnt_r, stab_cnt_n_s;
   logic [7:0]    mem_seg_r;
   logic [3:0]    mem_an_r;
   logic          mem_load_s;
   logic          capture_s;
   logic          same_s;
   logic          onehot_s;
   logic [4:0]    dec_s;
   logic [1:0]    pos_s;
   logic [3:0]    restart_s;
   logic [3:0]    set_s;
   logic [15:0]   digits_r;
   logic [3:0]    dp_r;
   logic          update_r;
   logic          err_r;

   // Input sample registers: all decisions use these.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_q_r <= 8'hFF;
         an_q_r  <= 4'hF;
      end else begin
         seg_q_r <= seg;
         an_q_r  <= an;
      end
   end

   assign same_s   = ({an_q_r, seg_q_r} == {mem_an_r, mem_seg_r});
   assign onehot_s = an_onehot(an_q_r);
   assign dec_s    = seg7_decode(mem_seg_r[6:0]);
   assign pos_s    = an_to_pos(mem_an_r);

   // State, stability counter and remembered bus value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         stab_cnt_r <= '0;
         mem_seg_r  <= 8'hFF;
         mem_an_r   <= 4'hF;
      end else begin
         state_r    <= state_n_s;
         stab_cnt_r <= stab_cnt_n_s;
         if (mem_load_s) begin
            mem_seg_r <= seg_q_r;
            mem_an_r  <= an_q_r;
         end
      end
   end

   // The output write is launched on the edge that enters CAPTURE, which gives
   // STABLE_CYCLES+1 cycles from the first stable bus cycle to the outputs.
   always_comb begin
      state_n_s    = state_r;
      stab_cnt_n_s = stab_cnt_r;
      mem_load_s   = 1'b0;
      capture_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (onehot_s) begin
               state_n_s    = ST_SETTLE;
               stab_cnt_n_s = SW'(1);
               mem_load_s   = 1'b1;
            end else begin
               state_n_s = ST_IDLE;
            end
         end
         ST_SETTLE, ST_HOLD: begin
            if (same_s) begin
               if (state_r == ST_HOLD) begin
                  state_n_s = ST_HOLD;
               end else if (stab_cnt_r >= STAB_LAST) begin
                  state_n_s    = ST_CAPTURE;
                  stab_cnt_n_s = SW'(STABLE_CYCLES);
                  capture_s    = 1'b1;
               end else begin
                  stab_cnt_n_s = stab_cnt_r + SW'(1);
               end
            end else if (onehot_s) begin
               state_n_s    = ST_SETTLE;
               stab_cnt_n_s = SW'(1);
               mem_load_s   = 1'b1;
            end else begin
               state_n_s    = ST_IDLE;
               stab_cnt_n_s = '0;
            end
         end
         ST_CAPTURE: begin
            state_n_s = ST_HOLD;
         end
         default: begin
            state_n_s    = ST_IDLE;
            stab_cnt_n_s = '0;
         end
      endcase
   end

   // Digit/dp storage, change pulse and sticky error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         digits_r <= 16'hFFFF;
         dp_r     <= 4'h0;
         update_r <= 1'b0;
         err_r    <= 1'b0;
      end else begin
         update_r <= 1'b0;
         if (capture_s) begin
            if (dec_s[4]) begin
               digits_r[{pos_s, 2'b00} +: 4] <= dec_s[3:0];
               dp_r[pos_s]                   <= ~mem_seg_r[7];
               update_r <= (digits_r[{pos_s, 2'b00} +: 4] != dec_s[3:0]) ||
                           (dp_r[pos_s] != ~mem_seg_r[7]);
            end else begin
               err_r <= 1'b1;
            end
         end
      end
   end

   // Per-position restart/set strobes for the stale timers.
   always_comb begin
      restart_s = 4'h0;
      set_s     = 4'h0;
      for (int i = 0; i < 4; i++) begin
         if (capture_s && (pos_s == 2'(i))) begin
            restart_s[i] = 1'b1;
            set_s[i]     = dec_s[4];
         end else begin
            restart_s[i] = 1'b0;
            set_s[i]     = 1'b0;
         end
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_stale
      seg_stale_timer #(
         .STALE_CYCLES(STALE_CYCLES)
      ) u_timer (
         .clk    (clk),
         .rst    (rst),
         .restart(restart_s[g]),
         .set    (set_s[g]),
         .valid  (valid[g])
      );
   end

`ifdef SEG_SCAN_DECODER_ERRCNT_EN
   logic [7:0] err_cnt_r;

   // Saturating count of illegal captures.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt_r <= 8'd0;
      end else if (capture_s && !dec_s[4] && (err_cnt_r != 8'd255)) begin
         err_cnt_r <= err_cnt_r + 8'd1;
      end
   end

   assign err_cnt = err_cnt_r;
`endif

   assign digits = digits_r;
   assign dp     = dp_r;
   assign update = update_r;
   assign err    = err_r;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed self-checking bench for seg_scan_decoder: vector table plus multi-cycle sequences.
module tb_seg_scan_decoder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  seg = 8'hFF;
   logic [3:0]  an  = 4'hF;
   logic [15:0] digits;
   logic [3:0]  dp;
   logic [3:0]  valid;
   logic        update;
   logic        err;
`ifdef SEG_SCAN_DECODER_ERRCNT_EN
   logic [7:0]  err_cnt;
`endif

   int tests  = 0;
   int failed = 0;

   seg_scan_decoder #(.STABLE_CYCLES(4), .STALE_CYCLES(1024)) dut (
      .clk    (clk),
      .rst    (rst),
      .seg    (seg),
      .an     (an),
      .digits (digits),
      .dp     (dp),
      .valid  (valid),
      .update (update),
      .err    (err)
`ifdef SEG_SCAN_DECODER_ERRCNT_EN
      ,.err_cnt(err_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  an;
      logic [7:0]  seg;
      logic [15:0] exp_digits;
      logic [3:0]  exp_valid;
      logic [3:0]  exp_dp;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " digits"}, digits, 16'hFFFF);
      check({tag, " dp"}, {12'h0, dp}, 16'h0);
      check({tag, " valid"}, {12'h0, valid}, 16'h0);
      check({tag, " update"}, {15'h0, update}, 16'h0);
      check({tag, " err"}, {15'h0, err}, 16'h0);
   endtask

   // Counts update pulses over n cycles and records the cycle of the last one.
   task automatic watch_update(input int n, output int pulses, output int at_k);
      pulses = 0;
      at_k   = 0;
      for (int k = 1; k <= n; k++) begin
         @(posedge clk); #1;
         if (update) begin
            pulses++;
            at_k = k;
         end
      end
   endtask

   initial begin
      int pulses;
      int at_k;
      int seen;

      vecs[0] = '{4'b1110, 8'hF9, 16'h0FF1, 4'b1001, 4'b0000};
      vecs[1] = '{4'b1101, 8'hA4, 16'h0F21, 4'b1011, 4'b0000};
      vecs[2] = '{4'b1011, 8'hB0, 16'h0321, 4'b1111, 4'b0000};
      vecs[3] = '{4'b0111, 8'h99, 16'h4321, 4'b1111, 4'b0000};
      vecs[4] = '{4'b1110, 8'h19, 16'h4324, 4'b1111, 4'b0001};
      vecs[5] = '{4'b1101, 8'hFF, 16'h43F4, 4'b1111, 4'b0001};
      vecs[6] = '{4'b1011, 8'h02, 16'h46F4, 4'b1111, 4'b0101};
      vecs[7] = '{4'b1100, 8'hC0, 16'h46F4, 4'b1111, 4'b0101};
      vecs[8] = '{4'b0111, 8'h00, 16'h86F4, 4'b1111, 4'b1101};

      // Reset state, then first capture latency on position 3.
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      an  = 4'b0111;
      seg = 8'hC0;
      pulses = 0;
      at_k   = 0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         if (update) begin
            pulses++;
            at_k = k;
         end
         if (k == 4) check("latency pre-capture digits", digits, 16'hFFFF);
      end
      check("first update count", 16'(pulses), 16'd1);
      check("first update cycle", 16'(at_k), 16'd5);
      check("first digits", digits, 16'h0FFF);
      check("first valid", {12'h0, valid}, 16'h0008);

      // Table of scan positions and glyphs, each held 8 cycles.
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         an  = vecs[i].an;
         seg = vecs[i].seg;
         repeat (8) @(posedge clk);
         @(negedge clk);
         check($sformatf("vec%0d digits", i), digits, vecs[i].exp_digits);
         check($sformatf("vec%0d valid", i), {12'h0, valid}, {12'h0, vecs[i].exp_valid});
         check($sformatf("vec%0d dp", i), {12'h0, dp}, {12'h0, vecs[i].exp_dp});
         check($sformatf("vec%0d err", i), {15'h0, err}, 16'h0);
      end

      // Glitch: 2 cycles of "0" then 4 cycles of "1"; the 0 must never appear.
      @(negedge clk);
      an  = 4'b1110;
      seg = 8'hC0;
      seen = 0;
      repeat (2) begin
         @(posedge clk); #1;
         if (digits[3:0] == 4'h0) seen++;
      end
      seg = 8'hF9;
      repeat (4) begin
         @(posedge clk); #1;
         if (digits[3:0] == 4'h0) seen++;
      end
      an  = 4'hF;
      seg = 8'hFF;
      repeat (6) begin
         @(posedge clk); #1;
         if (digits[3:0] == 4'h0) seen++;
      end
      check("glitch never shown", 16'(seen), 16'd0);
      check("glitch final digit", {12'h0, digits[3:0]}, 16'h0001);

      // Blank glyph, then an illegal glyph on position 0.
      @(negedge clk);
      an  = 4'b1110;
      seg = 8'hFF;
      repeat (6) @(posedge clk);
      @(negedge clk);
      check("blank digit", {12'h0, digits[3:0]}, 16'h000F);
      check("blank valid0", {15'h0, valid[0]}, 16'h1);
      seg = 8'h55;
      watch_update(8, pulses, at_k);
      @(negedge clk);
      check("illegal err", {15'h0, err}, 16'h1);
      check("illegal digit kept", {12'h0, digits[3:0]}, 16'h000F);
      check("illegal valid0 kept", {15'h0, valid[0]}, 16'h1);
      check("illegal no update", 16'(pulses), 16'd0);
`ifdef SEG_SCAN_DECODER_ERRCNT_EN
      check("err_cnt", {8'h0, err_cnt}, 16'd1);
`endif

      // Stale expiry: capture "0" on position 0, then stop refreshing.
      seg = 8'hC0;
      seen = 0;
      for (int k = 0; k < 20 && seen == 0; k++) begin
         @(posedge clk); #1;
         if (update) seen = 1;
      end
      check("stale capture seen", 16'(seen), 16'd1);
      an  = 4'hF;
      seg = 8'hFF;
      repeat (1023) @(posedge clk);
      #1;
      check("stale valid0 at 1023", {15'h0, valid[0]}, 16'h1);
      @(posedge clk); #1;
      check("stale valid0 at 1024", {15'h0, valid[0]}, 16'h0);
      check("stale digit retained", {12'h0, digits[3:0]}, 16'h0000);
      check("err sticky", {15'h0, err}, 16'h1);
      @(negedge clk);
      an  = 4'b1110;
      seg = 8'hF9;
      repeat (8) @(posedge clk);
      @(negedge clk);
      check("recapture valid0", {15'h0, valid[0]}, 16'h1);
      check("recapture digit", {12'h0, digits[3:0]}, 16'h0001);

      // Two anodes low never captures.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      an  = 4'b1100;
      seg = 8'hC0;
      watch_update(12, pulses, at_k);
      check("two-low valid", {12'h0, valid}, 16'h0);
      check("two-low digits", digits, 16'hFFFF);
      check("two-low no update", 16'(pulses), 16'd0);

      // Reset mid-settle, then a full-latency capture afterwards.
      @(negedge clk);
      an  = 4'b1110;
      seg = 8'hC0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check_reset_outputs("mid-settle rst");
      @(negedge clk);
      rst = 1'b0;
      watch_update(10, pulses, at_k);
      check("post-rst update cycle", 16'(at_k), 16'd5);
      check("post-rst digits", digits, 16'hFFF0);
      check("post-rst valid", {12'h0, valid}, 16'h0001);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
